// File: rtl/lc3_wb_pkg.sv
// Shared types and condition-code encoding for the LC3 writeback stage.
package lc3_wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2,
    WB_NPC = 2'd3
  } wb_src_e;

  localparam logic [2:0] PSR_N    = 3'b100;
  localparam logic [2:0] PSR_Z    = 3'b010;
  localparam logic [2:0] PSR_P    = 3'b001;
  localparam logic [2:0] PSR_NONE = 3'b000;

  // Takes the result's sign bit and zero flag so it stays width-independent.
  function automatic logic [2:0] nzp(input logic sign, input logic zero);
    if (sign) begin
      return PSR_N;
    end else if (zero) begin
      return PSR_Z;
    end
    return PSR_P;
  endfunction

endpackage

// File: rtl/lc3_regfile.sv
// Register file with one write port and RD_PORTS registered read ports,
// optionally forwarding the same-cycle write to matching reads.
module lc3_regfile #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned REG_CNT  = 8,
  parameter int unsigned RD_PORTS = 2,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned AW      = $clog2(REG_CNT)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         we,
  input  logic [AW-1:0]                waddr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [RD_PORTS*AW-1:0]       raddr,
  output logic [RD_PORTS*DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0]          regs [REG_CNT];
  logic [RD_PORTS*DATA_W-1:0] rdata_d;
  logic [RD_PORTS*DATA_W-1:0] rdata_q;

  always_comb begin
    rdata_d = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      rdata_d[k*DATA_W +: DATA_W] = regs[raddr[k*AW +: AW]];
      if ((BYPASS != 0) && we && (raddr[k*AW +: AW] == waddr)) begin
        rdata_d[k*DATA_W +: DATA_W] = wdata;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < REG_CNT; i++) begin
        regs[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we) begin
        regs[waddr] <= wdata;
      end
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lc3_writeback_rf.sv
// LC3 writeback stage: result source mux, N/Z/P condition codes and the
// architectural register file with registered read ports.
module lc3_writeback_rf
  import lc3_wb_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned REG_CNT  = 8,
  parameter int unsigned RD_PORTS = 2,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned AW      = $clog2(REG_CNT)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable_writeback,
  input  logic [1:0]                 W_Control,
  input  logic [DATA_W-1:0]          aluout,
  input  logic [DATA_W-1:0]          memout,
  input  logic [DATA_W-1:0]          pcout,
  input  logic [DATA_W-1:0]          npc,
  input  logic [AW-1:0]              dr,
  input  logic [RD_PORTS*AW-1:0]     sr,
  output logic [RD_PORTS*DATA_W-1:0] d_out,
  output logic [DATA_W-1:0]          wb_data,
  output logic [2:0]                 psr
);

  wb_src_e    wb_src;
  logic [2:0] psr_q;

  assign wb_src = wb_src_e'(W_Control);

  always_comb begin
    wb_data = '0;
    unique case (wb_src)
      WB_ALU: wb_data = aluout;
      WB_MEM: wb_data = memout;
      WB_PC:  wb_data = pcout;
      WB_NPC: wb_data = npc;
      default: wb_data = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      psr_q <= PSR_NONE;
    end else if (enable_writeback) begin
      psr_q <= nzp(wb_data[DATA_W-1], wb_data == '0);
    end
  end

  assign psr = psr_q;

  lc3_regfile #(
    .DATA_W   (DATA_W),
    .REG_CNT  (REG_CNT),
    .RD_PORTS (RD_PORTS),
    .BYPASS   (BYPASS)
  ) u_regfile (
    .clock (clock),
    .reset (reset),
    .we    (enable_writeback),
    .waddr (dr),
    .wdata (wb_data),
    .raddr (sr),
    .rdata (d_out)
  );

endmodule
